// File: rtl/tlb_op_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tlb_op_ctrl
// Description : TLB maintenance sequencer between commit and the tlb block.
//               Accepts one TLBSRCH / TLBRD / TLBWR / TLBFILL / INVTLB request
//               at a time, drives the TLB search / write / fill / invalidate
//               strobes, captures search and read results, and issues the
//               CSR write-backs for TLBIDX, TLBEHI, TLBELO0, TLBELO1 and ASID.
//               Also provides the TLBFILL replacement index.
//
// Ports       : clk, rst (async, active high)
//               op_valid/op_ready/op_type/op_inv_op  request handshake
//               csr_tlbehi, csr_tlbidx               current CSR values
//               srch_fetch, srch_vppn                search request
//               tlb_found, tlb_index                 search result
//               tlbwr_en, tlbfill_en, rand_index     write / fill strobes
//               invtlb_en                            invalidate strobe
//               rd_*                                 TLB read data
//               wb_we, wb_*                          CSR write-back
//               done, done_ill                       completion pulse
//
// Config      : TLB_FILL_LFSR_EN - when defined the fill index source is a
//               maximal-length Galois LFSR (seed 1) instead of an up counter.
//
// Revision    : 1.0  initial release
//==============================================================================
module tlb_op_ctrl #(
    parameter int TLBNUM = 32,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [2:0]    op_type,
    input  logic [4:0]    op_inv_op,
    input  logic [31:0]   csr_tlbehi,
    input  logic [31:0]   csr_tlbidx,
    output logic          srch_fetch,
    output logic [18:0]   srch_vppn,
    input  logic          tlb_found,
    input  logic [IW-1:0] tlb_index,
    output logic          tlbwr_en,
    output logic          tlbfill_en,
    output logic [IW-1:0] rand_index,
    output logic          invtlb_en,
    input  logic [31:0]   rd_tlbehi,
    input  logic [31:0]   rd_tlbelo0,
    input  logic [31:0]   rd_tlbelo1,
    input  logic [31:0]   rd_tlbidx,
    input  logic [9:0]    rd_asid,
    output logic [4:0]    wb_we,
    output logic [31:0]   wb_tlbidx,
    output logic [31:0]   wb_tlbehi,
    output logic [31:0]   wb_tlbelo0,
    output logic [31:0]   wb_tlbelo1,
    output logic [9:0]    wb_asid,
    output logic          done,
    output logic          done_ill
);

    localparam logic [2:0] c_OP_SRCH = 3'd0;
    localparam logic [2:0] c_OP_RD   = 3'd1;
    localparam logic [2:0] c_OP_WR   = 3'd2;
    localparam logic [2:0] c_OP_FILL = 3'd3;
    localparam logic [2:0] c_OP_INV  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic          r_ill;
    logic [18:0]   r_vppn;
    logic [IW-1:0] r_rand_idx;
    logic [IW-1:0] r_rand_src;
    logic [4:0]    r_wb_we;
    logic [31:0]   r_wb_idx;
    logic [31:0]   r_wb_ehi;
    logic [31:0]   r_wb_elo0;
    logic [31:0]   r_wb_elo1;
    logic [9:0]    r_wb_asid;

    logic          w_accept;
    logic          w_illegal;
    logic          w_in_done;
    logic [IW-1:0] w_rand_next;

    // Only the VPPN field of TLBEHI and the NE/PS fields of the read TLBIDX
    // are consumed here.
    logic w_unused;
    assign w_unused = &{1'b0, csr_tlbehi[12:0], rd_tlbidx[30], rd_tlbidx[23:0]};

    assign w_accept  = op_valid && (r_state == S_IDLE);
    assign w_illegal = (op_type > c_OP_INV) ||
                       ((op_type == c_OP_INV) && (op_inv_op > 5'd6));
    assign w_in_done = (r_state == S_DONE);

    //--------------------------------------------------------------------------
    // Fill index source: advances every cycle regardless of FSM state.
    //--------------------------------------------------------------------------
`ifdef TLB_FILL_LFSR_EN
    // Galois feedback masks for maximal-length sequences, IW = 2..5.
    function automatic int lfsr_taps(input int w);
        case (w)
            2:       return 'b11;
            3:       return 'b110;
            4:       return 'b1100;
            default: return 'b10100;   // x^5 + x^3 + 1
        endcase
    endfunction

    localparam logic [IW-1:0] c_LFSR_TAPS = IW'(lfsr_taps(IW));
    localparam logic [IW-1:0] c_SRC_SEED  = IW'(1);

    assign w_rand_next = r_rand_src[0] ? ((r_rand_src >> 1) ^ c_LFSR_TAPS)
                                       : (r_rand_src >> 1);
`else
    localparam logic [IW-1:0] c_SRC_SEED  = '0;

    // TLBNUM is a power of two, so natural IW-bit wrap gives 0..TLBNUM-1.
    assign w_rand_next = r_rand_src + IW'(1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rand_src <= c_SRC_SEED;
        end else begin
            r_rand_src <= w_rand_next;
        end
    end

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    //--------------------------------------------------------------------------
    // Next state and decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        op_ready   = 1'b0;
        srch_fetch = 1'b0;
        tlbwr_en   = 1'b0;
        tlbfill_en = 1'b0;
        invtlb_en  = 1'b0;
        done       = 1'b0;
        done_ill   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next = w_illegal ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // RD has no strobe: the read port is addressed by csr_tlbidx.
                srch_fetch = (r_op == c_OP_SRCH);
                tlbwr_en   = (r_op == c_OP_WR);
                tlbfill_en = (r_op == c_OP_FILL);
                invtlb_en  = (r_op == c_OP_INV);
                w_next     = ((r_op == c_OP_SRCH) || (r_op == c_OP_RD)) ? S_RESP
                                                                        : S_DONE;
            end
            S_RESP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                done_ill = r_ill;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Write-back is visible only during the DONE cycle.
    assign wb_we      = w_in_done ? r_wb_we   : '0;
    assign wb_tlbidx  = w_in_done ? r_wb_idx  : '0;
    assign wb_tlbehi  = w_in_done ? r_wb_ehi  : '0;
    assign wb_tlbelo0 = w_in_done ? r_wb_elo0 : '0;
    assign wb_tlbelo1 = w_in_done ? r_wb_elo1 : '0;
    assign wb_asid    = w_in_done ? r_wb_asid : '0;

    assign srch_vppn  = r_vppn;
    assign rand_index = r_rand_idx;

    //--------------------------------------------------------------------------
    // Request latch and result capture
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op       <= '0;
            r_ill      <= 1'b0;
            r_vppn     <= '0;
            r_rand_idx <= '0;
            r_wb_we    <= '0;
            r_wb_idx   <= '0;
            r_wb_ehi   <= '0;
            r_wb_elo0  <= '0;
            r_wb_elo1  <= '0;
            r_wb_asid  <= '0;
        end else if (w_accept) begin
            r_op       <= op_type;
            r_ill      <= w_illegal;
            r_vppn     <= csr_tlbehi[31:13];
            r_rand_idx <= r_rand_src;
            // Cleared here so ops without a RESP phase write back nothing.
            r_wb_we    <= '0;
            r_wb_idx   <= '0;
            r_wb_ehi   <= '0;
            r_wb_elo0  <= '0;
            r_wb_elo1  <= '0;
            r_wb_asid  <= '0;
        end else if (r_state == S_RESP) begin
            if (r_op == c_OP_SRCH) begin
                r_wb_we  <= 5'b00001;
                r_wb_idx <= tlb_found ? {1'b0, csr_tlbidx[30:IW], tlb_index}
                                      : {1'b1, csr_tlbidx[30:0]};
            end else begin
                r_wb_we <= 5'b11111;
                if (!rd_tlbidx[31]) begin
                    r_wb_idx  <= {1'b0, csr_tlbidx[30], rd_tlbidx[29:24],
                                  csr_tlbidx[23:0]};
                    r_wb_ehi  <= rd_tlbehi;
                    r_wb_elo0 <= rd_tlbelo0;
                    r_wb_elo1 <= rd_tlbelo1;
                    r_wb_asid <= rd_asid;
                end else begin
                    // Empty entry: mark NE, clear PS and the entry contents.
                    r_wb_idx  <= {1'b1, csr_tlbidx[30], 6'b0, csr_tlbidx[23:0]};
                    r_wb_ehi  <= '0;
                    r_wb_elo0 <= '0;
                    r_wb_elo1 <= '0;
                    r_wb_asid <= '0;
                end
            end
        end
    end

endmodule
`default_nettype wire
